// File: rtl/dft12_twiddle_sequencer.sv
// rtl/dft12_twiddle_sequencer.sv - twiddle ROM address sequencer for the 4x3 DFT12
// Walks i = 0..11 per symbol and addresses W12^(k1*n2) (or its conjugate), with optional ROM register alignment.
module dft12_twiddle_sequencer #(
  parameter int TW_FF = 0,
  parameter int SYM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             inv,
  input  logic [SYM_W-1:0] num_sym,
  output logic             busy,
  output logic             done,
  output logic             err_start,
  output logic [10:0]      tw_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_idx,
  output logic             out_last,
  output logic             out_job_last
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             inv_q, inv_d;
  logic [SYM_W-1:0] nsym_q, nsym_d;
  logic [3:0]       i0_q, i0_d;
  logic [SYM_W-1:0] s0_q, s0_d;
  logic             issued_q, issued_d;
  logic             v1_q, v1_d;
  logic [3:0]       a1_q, a1_d;
  logic [3:0]       idx1_q, idx1_d;
  logic             last1_q, last1_d;
  logic             jlast1_q, jlast1_d;

  logic       v0, adv, take, i0_last, s0_last;
  logic [3:0] a0;

  function automatic logic [3:0] tw_entry(input logic [3:0] i, input logic conj);
    logic [3:0] k1, n2, e;
    k1 = i / 4'd3;
    n2 = i % 4'd3;
    e  = k1 * n2;
    return (conj && e != 4'd0) ? 4'd12 - e : e;
  endfunction

  always_comb begin
    state_d  = state_q;
    inv_d    = inv_q;
    nsym_d   = nsym_q;
    i0_d     = i0_q;
    s0_d     = s0_q;
    issued_d = issued_q;
    v1_d     = v1_q;
    a1_d     = a1_q;
    idx1_d   = idx1_q;
    last1_d  = last1_q;
    jlast1_d = jlast1_q;

    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    err_start = start && busy;

    v0      = (state_q == RUN) && !issued_q;
    a0      = tw_entry(i0_q, inv_q);
    i0_last = (i0_q == 4'd11);
    s0_last = (s0_q == nsym_q - 1'b1);

    // Stall re-addresses the held entry so a registered ROM keeps its data stable.
    if (TW_FF == 0) begin
      adv          = out_ready;
      out_valid    = v0;
      out_idx      = v0 ? i0_q : 4'd0;
      out_last     = v0 && i0_last;
      out_job_last = v0 && i0_last && s0_last;
      tw_addr      = {7'd0, v0 ? a0 : 4'd0};
    end else begin
      adv          = !v1_q || out_ready;
      out_valid    = v1_q;
      out_idx      = idx1_q;
      out_last     = last1_q;
      out_job_last = jlast1_q;
      tw_addr      = {7'd0, adv ? (v0 ? a0 : 4'd0) : a1_q};
    end

    take = v0 && adv;
    if (take) begin
      if (i0_last) begin
        i0_d = 4'd0;
        if (s0_last) issued_d = 1'b1;
        else         s0_d     = s0_q + 1'b1;
      end else begin
        i0_d = i0_q + 4'd1;
      end
    end

    if (TW_FF != 0 && adv) begin
      v1_d     = v0;
      a1_d     = v0 ? a0 : 4'd0;
      idx1_d   = v0 ? i0_q : 4'd0;
      last1_d  = v0 && i0_last;
      jlast1_d = v0 && i0_last && s0_last;
    end

    case (state_q)
      IDLE: if (start) begin
        inv_d    = inv;
        nsym_d   = num_sym;
        i0_d     = 4'd0;
        s0_d     = '0;
        issued_d = 1'b0;
        v1_d     = 1'b0;
        state_d  = (num_sym == '0) ? DONE : RUN;
      end
      RUN:     if (out_valid && out_ready && out_job_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      inv_q    <= 1'b0;
      nsym_q   <= '0;
      i0_q     <= 4'd0;
      s0_q     <= '0;
      issued_q <= 1'b0;
      v1_q     <= 1'b0;
      a1_q     <= 4'd0;
      idx1_q   <= 4'd0;
      last1_q  <= 1'b0;
      jlast1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      inv_q    <= inv_d;
      nsym_q   <= nsym_d;
      i0_q     <= i0_d;
      s0_q     <= s0_d;
      issued_q <= issued_d;
      v1_q     <= v1_d;
      a1_q     <= a1_d;
      idx1_q   <= idx1_d;
      last1_q  <= last1_d;
      jlast1_q <= jlast1_d;
    end
  end

endmodule

// File: tb/tb_dft12_twiddle_sequencer.sv
// tb/tb_dft12_twiddle_sequencer.sv - bench for both ROM alignment settings of the twiddle sequencer
// Drives directed and random jobs into a TW_FF=0 and a TW_FF=1 instance, each feeding its own ROM model.
module tb_dft12_twiddle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       ready0 = 1'b0, ready1 = 1'b0;
  logic       inv = 1'b0;
  logic [7:0] num_sym = 8'd0;

  logic        busy0, done0, err0, valid0, last0, jlast0;
  logic        busy1, done1, err1, valid1, last1, jlast1;
  logic [10:0] addr0, addr1;
  logic [3:0]  idx0, idx1;
  logic [7:0]  rom0, rom1_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int addr;
    bit last;
    bit jlast;
  } exp_t;

  always #5 clk = ~clk;

  dft12_twiddle_sequencer #(.TW_FF(0), .SYM_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .inv(inv), .num_sym(num_sym),
    .busy(busy0), .done(done0), .err_start(err0), .tw_addr(addr0),
    .out_valid(valid0), .out_ready(ready0), .out_idx(idx0),
    .out_last(last0), .out_job_last(jlast0)
  );

  dft12_twiddle_sequencer #(.TW_FF(1), .SYM_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .inv(inv), .num_sym(num_sym),
    .busy(busy1), .done(done1), .err_start(err1), .tw_addr(addr1),
    .out_valid(valid1), .out_ready(ready1), .out_idx(idx1),
    .out_last(last1), .out_job_last(jlast1)
  );

  function automatic logic [7:0] rom_content(input int a);
    return 8'((a * 29 + 7) & 255);
  endfunction

  assign rom0 = rom_content(int'(addr0));
  always @(posedge clk) rom1_q <= rom_content(int'(addr1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_zero(input int sel, input string tag);
    if (sel == 0) chk(tag, {busy0, done0, err0, valid0, last0, jlast0, idx0, addr0}, 32'd0);
    else          chk(tag, {busy1, done1, err1, valid1, last1, jlast1, idx1, addr1}, 32'd0);
  endtask

  task automatic run_job(input int sel, input bit j_inv, input int n, input int rmode,
                         input bit do_stall, input int err_cyc, input int rst_after);
    exp_t q[$];
    exp_t x;
    int xfers, done_cnt, busy_cnt, stall_cnt, last_xfer_cyc, done_cyc;
    bit finished, prev_valid, r, v, rdy;
    xfers = 0; done_cnt = 0; busy_cnt = 0; stall_cnt = 0;
    last_xfer_cyc = -1; done_cyc = -1; finished = 0; prev_valid = 0;
    for (int s = 0; s < n; s++)
      for (int i = 0; i < 12; i++) begin
        int e;
        e = (i / 3) * (i % 3);
        x.idx = i;
        x.addr = j_inv ? (12 - e) % 12 : e;
        x.last = (i == 11);
        x.jlast = (i == 11) && (s == n - 1);
        q.push_back(x);
      end

    @(posedge clk); #1;
    inv = j_inv;
    num_sym = 8'(n);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    chk("idle_busy", sel ? busy1 : busy0, 0);
    @(posedge clk); #1;

    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      r = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (do_stall && prev_valid && q.size() > 0 && q[0].idx == 4 && stall_cnt < 5) begin
        r = 1'b0;
        stall_cnt++;
      end
      start0 = 1'b0;
      start1 = 1'b0;
      if (cyc == err_cyc) begin
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        inv = ~inv;
        num_sym = num_sym + 8'd3;
      end
      if (sel == 0) ready0 = r; else ready1 = r;

      if (rst_after >= 0 && xfers == rst_after) begin
        rst_n = 1'b0;
        #1;
        chk_zero(sel, "rst_outputs");
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_done", sel ? done1 : done0, 0);
        chk("rst_idle", sel ? busy1 : busy0, 0);
        finished = 1;
        break;
      end

      @(negedge clk);
      v   = sel ? valid1 : valid0;
      rdy = sel ? ready1 : ready0;
      chk("err_start", sel ? err1 : err0, (cyc == err_cyc) ? 1 : 0);
      if (v) begin
        if (q.size() == 0) begin
          chk("extra_valid", 1, 0);
        end else begin
          chk("idx", sel ? idx1 : idx0, q[0].idx);
          chk("rom_data", sel ? rom1_q : rom0, rom_content(q[0].addr));
          chk("last", sel ? last1 : last0, q[0].last);
          chk("job_last", sel ? jlast1 : jlast0, q[0].jlast);
          if (sel == 0) chk("tw_addr", addr0, q[0].addr);
          if (rdy) begin
            void'(q.pop_front());
            xfers++;
            if (q.size() == 0) last_xfer_cyc = cyc;
          end
        end
      end else if (sel == 0) begin
        chk("tw_addr_idle", addr0, 0);
      end
      if (sel ? busy1 : busy0) busy_cnt++;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("post_done_busy", sel ? busy1 : busy0, 0);
        chk("post_done_pulse", sel ? done1 : done0, 0);
        finished = 1;
      end
      if (sel ? done1 : done0) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          chk("done_timing", cyc, last_xfer_cyc + 1);
        end
      end
      prev_valid = v;
      @(posedge clk); #1;
    end

    start0 = 1'b0; start1 = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
    if (!finished) chk("timeout", 0, 1);
    if (rst_after >= 0) begin
      chk("rst_xfers", xfers, rst_after);
      chk("rst_done_cnt", done_cnt, 0);
    end else begin
      chk("xfer_count", xfers, 12 * n);
      chk("done_cnt", done_cnt, 1);
      if (n == 0) chk("zero_busy_cycles", busy_cnt, 1);
      if (do_stall) chk("stall_len", stall_cnt, 5);
    end
  endtask

  initial begin
    #1;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_job(0, 1'b0, 1, 0, 1'b0, -1, -1);
    run_job(1, 1'b1, 2, 0, 1'b0, -1, -1);
    run_job(1, 1'b0, 1, 1, 1'b1, -1, -1);
    run_job(0, 1'b0, 0, 0, 1'b0, -1, -1);
    run_job(1, 1'b1, 0, 0, 1'b0, -1, -1);
    run_job(0, 1'b0, 2, 0, 1'b0, 5, -1);
    run_job(1, 1'b1, 2, 1, 1'b0, 6, -1);
    run_job(1, 1'b1, 3, 1, 1'b0, -1, 19);
    run_job(1, 1'b0, 1, 1, 1'b0, -1, -1);
    run_job(0, 1'b1, 3, 1, 1'b0, -1, 19);
    run_job(0, 1'b1, 1, 0, 1'b0, -1, -1);
    for (int k = 0; k < 6; k++)
      run_job(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(1, 3)), 1, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dft12_twiddle_sequencer.md
Name: dft12_twiddle_sequencer

Overview:
Sequences the 12-entry twiddle ROM for the 12-point DFT/IDFT used in PUSCH transform precoding. The DFT is decomposed 4x3, and the block drives the ROM address for the inter-stage twiddle W12^(k1*n2) of every sample of every symbol in a job. A valid/ready handshake feeds the butterfly datapath, and a latency parameter aligns valid with the registered or unregistered ROM output. A start/busy/done handshake connects it to the PUSCH symbol controller.

Parameters:
TW_FF, 0, ROM output-register setting. Must equal the ROM instance's TW_FF. 0 = combinational read, 1 = one-cycle registered read.
SYM_W, 8, width of the symbol-count input.

Ports:
clk  in  1  master clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle job request; sampled only in IDLE.
inv  in  1  0 = forward DFT twiddles, 1 = conjugate (IDFT). Latched at start.
num_sym  in  SYM_W  number of 12-sample symbols in the job. Latched at start.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse at job completion.
err_start  out  1  one-cycle pulse when start is high while busy.
tw_addr  out  11  ROM address; value is always 0..11.
out_valid  out  1  the ROM output currently carries a valid twiddle.
out_ready  in  1  datapath accepts the twiddle when out_valid && out_ready.
out_idx  out  4  sample index i (0..11) of the presented twiddle.
out_last  out  1  i == 11.
out_job_last  out  1  i == 11 on the final symbol.

Behaviour:
- Reset values: all outputs 0, state IDLE.
- Reset mid-job aborts immediately. No done pulse is produced.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start with num_sym != 0.
  - IDLE -> DONE on start with num_sym == 0. done pulses the next cycle and no out_valid is produced.
  - RUN -> DONE when the element with out_job_last is accepted.
  - DONE -> IDLE unconditionally after 1 cycle, with done = 1 in that cycle.
- busy = (state != IDLE). A start seen in RUN or DONE sets err_start = 1 for one cycle and is otherwise ignored.
- Index generation: i counts 0..11, with k1 = i/3 and n2 = i%3.
  - e = k1*n2 gives the sequence 0,0,0,0,1,2,0,2,4,0,3,6.
  - Addressed entry is e when inv = 0, and (12-e) mod 12 when inv = 1. The inv = 1 sequence is 0,0,0,0,11,10,0,10,8,0,9,6.
  - Sequence order is i-major within a symbol; the symbol counter wraps i from 11 to 0.
- Handshake: an element is transferred when out_valid && out_ready. out_valid stays asserted, and out_idx, out_last and the ROM data hold stable, until the element is accepted. Full throughput is one element per cycle while out_ready = 1.
- TW_FF = 0:
  - tw_addr presents the current element combinationally, so out_valid and the ROM output appear in the same cycle.
  - First out_valid occurs 1 cycle after start.
- TW_FF = 1: two-stage pipeline.
  - Issue stage holds address a0 with valid v0. Output stage holds a1, v1, idx, last. out_valid = v1.
  - Advance condition: !v1 || out_ready.
  - When advancing, tw_addr = a0. When stalled (v1 && !out_ready), tw_addr = a1, so the ROM register re-reads the held entry.
  - First out_valid occurs 2 cycles after start.
  - No element may be dropped or duplicated across any stall pattern.
- Total accepted elements per job = 12*num_sym. The symbol count saturates at num_sym; no wrap beyond the job.
- tw_addr = 0 whenever no element is issued.

Test Plan:
1. TW_FF=0, inv=0, num_sym=1, out_ready=1 -> 12 consecutive valids carrying addr 0,0,0,0,1,2,0,2,4,0,3,6. out_last and out_job_last high on i=11. done pulses 1 cycle after the last transfer.
2. TW_FF=1, inv=1, num_sym=2, out_ready=1 -> 24 valids repeating 0,0,0,0,11,10,0,10,8,0,9,6. Each twiddle matches the ROM content for the addressed entry on the valid cycle. out_job_last only at element 24.
3. TW_FF=1, num_sym=1, out_ready toggling (random, plus a 5-cycle low during i=4) -> output held at i=4 for the full stall with twiddle = entry 1 throughout. Exactly 12 transfers in order.
4. start with num_sym=0 -> no out_valid. busy high 1 cycle, done pulses once, return to IDLE.
5. start again while RUN -> err_start pulses once. The sequence continues unchanged and inv/num_sym are not re-latched.
6. rst_n low at i=7 of symbol 1 -> all outputs 0 asynchronously with no done pulse. A new start afterwards begins again at i=0 of symbol 0.
